// File: rtl/jump_ras_unit.sv
// jump_ras_unit: execute-stage jump unit with a circular return-address stack.
//
// Resolves JAL/JALR, produces the link value (pc+4) for rd, redirects the PC and
// squashes younger instructions for FLUSH_CYCLES cycles after every redirect.
// A return-address stack follows the RISC-V link-register hints (x1/x5) and flags
// return mispredictions. Misaligned targets raise a one-cycle exception instead.
//
// Ports:
//   i_clk, i_rst            clock (rising edge), async active-low reset
//   i_valid, jump_control   instruction valid, 00 none / 01 JAL / 10 JALR / 11 none
//   pc, imm, rs1_val        operands; rs1_idx, rd_idx register indices
//   rd_write_control/_val   link write to rd (pulse / held value)
//   pc_update_control/_val  redirect (pulse / held target)
//   ignore_curr_inst        high while the flush counter is non-zero
//   misaligned_exc          one-cycle target-misaligned exception
//   ras_top/_valid/_count   RAS status; ras_mispredict pulses on a wrong return
module jump_ras_unit #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned RAS_DEPTH    = 8,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned ALIGN_BITS   = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    input  logic [XLEN-1:0]                pc,
    input  logic [XLEN-1:0]                imm,
    input  logic [XLEN-1:0]                rs1_val,
    input  logic [4:0]                     rs1_idx,
    input  logic [4:0]                     rd_idx,
    input  logic [1:0]                     jump_control,
    output logic                           rd_write_control,
    output logic [XLEN-1:0]                rd_write_val,
    output logic                           pc_update_control,
    output logic [XLEN-1:0]                pc_update_val,
    output logic                           ignore_curr_inst,
    output logic                           misaligned_exc,
    output logic [XLEN-1:0]                ras_top,
    output logic                           ras_valid,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_mispredict
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned FC_W  = $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] JC_JAL  = 2'b01;
    localparam logic [1:0] JC_JALR = 2'b10;

    // Registered outputs and state
    logic              rd_write_control_q, rd_write_control_d;
    logic [XLEN-1:0]   rd_write_val_q, rd_write_val_d;
    logic              pc_update_control_q, pc_update_control_d;
    logic [XLEN-1:0]   pc_update_val_q, pc_update_val_d;
    logic              misaligned_exc_q, misaligned_exc_d;
    logic              ras_mispredict_q, ras_mispredict_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [PTR_W-1:0]  ras_ptr_q, ras_ptr_d;   // next free slot
    logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
    logic [XLEN-1:0]   ras_mem_q [RAS_DEPTH];

    // Datapath
    logic              accept, is_jal, misaligned, jump_ok;
    logic              rd_link, rs1_link, do_push, do_pop, pop_hit;
    logic [XLEN-1:0]   link_val, jal_target, jalr_sum, target, popped;
    logic [PTR_W-1:0]  ptr_after_pop;
    logic [CNT_W-1:0]  cnt_after_pop;
    logic              ras_wr_en;
    logic [PTR_W-1:0]  ras_wr_idx;

    always_comb begin
        accept     = i_valid && (jump_control == JC_JAL || jump_control == JC_JALR) &&
                     (flush_cnt_q == '0);
        is_jal     = (jump_control == JC_JAL);
        link_val   = pc + XLEN'(4);
        jal_target = pc + imm;
        jalr_sum   = rs1_val + imm;
        target     = is_jal ? jal_target : (jalr_sum & ~XLEN'(1));
        misaligned = |target[ALIGN_BITS-1:0];
        jump_ok    = accept && !misaligned;

        rd_link  = (rd_idx == 5'd1) || (rd_idx == 5'd5);
        rs1_link = (rs1_idx == 5'd1) || (rs1_idx == 5'd5);

        // Link-register hint table; the rd!=rs1 both-link case is a coroutine swap.
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (is_jal) begin
            do_push = rd_link;
        end else begin
            do_push = rd_link;
            do_pop  = rs1_link && (!rd_link || (rd_idx != rs1_idx));
        end
        do_push = do_push && jump_ok;
        do_pop  = do_pop && jump_ok;
    end

    always_comb begin
        popped        = ras_mem_q[ras_ptr_q - PTR_W'(1)];
        pop_hit       = do_pop && (ras_cnt_q != '0);
        ptr_after_pop = pop_hit ? ras_ptr_q - PTR_W'(1) : ras_ptr_q;
        cnt_after_pop = pop_hit ? ras_cnt_q - CNT_W'(1) : ras_cnt_q;

        // A push into a full stack lands on the oldest slot as the pointer wraps.
        ras_wr_en  = do_push;
        ras_wr_idx = ptr_after_pop;
        ras_ptr_d  = do_push ? ptr_after_pop + PTR_W'(1) : ptr_after_pop;
        ras_cnt_d  = cnt_after_pop;
        if (do_push && cnt_after_pop != CNT_W'(RAS_DEPTH)) begin
            ras_cnt_d = cnt_after_pop + CNT_W'(1);
        end
    end

    always_comb begin
        rd_write_control_d  = 1'b0;
        rd_write_val_d      = rd_write_val_q;
        pc_update_control_d = 1'b0;
        pc_update_val_d     = pc_update_val_q;
        misaligned_exc_d    = 1'b0;
        ras_mispredict_d    = 1'b0;
        flush_cnt_d         = flush_cnt_q;
        if (flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - FC_W'(1);
        end
        if (accept && misaligned) begin
            misaligned_exc_d = 1'b1;
        end
        if (jump_ok) begin
            rd_write_control_d  = (rd_idx != 5'd0);
            rd_write_val_d      = link_val;
            pc_update_control_d = 1'b1;
            pc_update_val_d     = target;
            ras_mispredict_d    = pop_hit && (popped != target);
            flush_cnt_d         = FC_W'(FLUSH_CYCLES);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rd_write_control_q  <= 1'b0;
            rd_write_val_q      <= '0;
            pc_update_control_q <= 1'b0;
            pc_update_val_q     <= '0;
            misaligned_exc_q    <= 1'b0;
            ras_mispredict_q    <= 1'b0;
            flush_cnt_q         <= '0;
            ras_ptr_q           <= '0;
            ras_cnt_q           <= '0;
        end else begin
            rd_write_control_q  <= rd_write_control_d;
            rd_write_val_q      <= rd_write_val_d;
            pc_update_control_q <= pc_update_control_d;
            pc_update_val_q     <= pc_update_val_d;
            misaligned_exc_q    <= misaligned_exc_d;
            ras_mispredict_q    <= ras_mispredict_d;
            flush_cnt_q         <= flush_cnt_d;
            ras_ptr_q           <= ras_ptr_d;
            ras_cnt_q           <= ras_cnt_d;
        end
    end

    // Entry storage needs no reset: ras_top is masked while the stack is empty.
    always_ff @(posedge i_clk) begin
        if (ras_wr_en) begin
            ras_mem_q[ras_wr_idx] <= link_val;
        end
    end

    assign rd_write_control  = rd_write_control_q;
    assign rd_write_val      = rd_write_val_q;
    assign pc_update_control = pc_update_control_q;
    assign pc_update_val     = pc_update_val_q;
    assign misaligned_exc    = misaligned_exc_q;
    assign ras_mispredict    = ras_mispredict_q;
    assign ignore_curr_inst  = (flush_cnt_q != '0);
    assign ras_count         = ras_cnt_q;
    assign ras_valid         = (ras_cnt_q != '0);
    assign ras_top           = ras_valid ? ras_mem_q[ras_ptr_q - PTR_W'(1)] : '0;

endmodule

// File: tb/tb_jump_ras_unit.sv
// Directed bench for jump_ras_unit: a default instance (ALIGN_BITS=2) plus a
// second instance with ALIGN_BITS=1 fed the same stimulus.
module tb_jump_ras_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] pc = '0, imm = '0, rs1_val = '0;
    logic [4:0]  rs1_idx = '0, rd_idx = '0;
    logic [1:0]  jc = '0;

    logic        rdw0, pcu0, ign0, mis0, rv0, mp0;
    logic [31:0] rdv0, pcv0, top0;
    logic [3:0]  cnt0;
    logic        rdw1, pcu1, ign1, mis1, rv1, mp1;
    logic [31:0] rdv1, pcv1, top1;
    logic [3:0]  cnt1;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    jump_ras_unit dut0 (
        .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .pc(pc), .imm(imm),
        .rs1_val(rs1_val), .rs1_idx(rs1_idx), .rd_idx(rd_idx), .jump_control(jc),
        .rd_write_control(rdw0), .rd_write_val(rdv0), .pc_update_control(pcu0),
        .pc_update_val(pcv0), .ignore_curr_inst(ign0), .misaligned_exc(mis0),
        .ras_top(top0), .ras_valid(rv0), .ras_count(cnt0), .ras_mispredict(mp0)
    );

    jump_ras_unit #(.ALIGN_BITS(1)) dut1 (
        .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .pc(pc), .imm(imm),
        .rs1_val(rs1_val), .rs1_idx(rs1_idx), .rd_idx(rd_idx), .jump_control(jc),
        .rd_write_control(rdw1), .rd_write_val(rdv1), .pc_update_control(pcu1),
        .pc_update_val(pcv1), .ignore_curr_inst(ign1), .misaligned_exc(mis1),
        .ras_top(top1), .ras_valid(rv1), .ras_count(cnt1), .ras_mispredict(mp1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one instruction for a single edge, sample 1 time unit after it.
    task automatic jump(input logic [1:0] c, input logic [31:0] p, input logic [31:0] im,
                        input logic [31:0] r1v, input logic [4:0] r1i, input logic [4:0] rdi);
        @(negedge clk);
        jc = c; pc = p; imm = im; rs1_val = r1v; rs1_idx = r1i; rd_idx = rdi;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        jc = 2'b00;
    endtask

    // Two more edges clear a 2-cycle flush.
    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_pcu", {31'd0, pcu0}, 32'd0);
        chk("rst_pcv", pcv0, 32'd0);
        chk("rst_rdv", rdv0, 32'd0);
        chk("rst_ign", {31'd0, ign0}, 32'd0);
        chk("rst_cnt", {28'd0, cnt0}, 32'd0);
        chk("rst_top", top0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // JAL pc=0x100 imm=0x20 rd=1
        jump(2'b01, 32'h100, 32'h20, 32'h0, 5'd0, 5'd1);
        chk("jal_rdv", rdv0, 32'h104);
        chk("jal_rdw", {31'd0, rdw0}, 32'd1);
        chk("jal_pcv", pcv0, 32'h120);
        chk("jal_pcu", {31'd0, pcu0}, 32'd1);
        chk("jal_top", top0, 32'h104);
        chk("jal_cnt", {28'd0, cnt0}, 32'd1);
        chk("jal_ign1", {31'd0, ign0}, 32'd1);
        @(posedge clk); #1;
        chk("jal_ign2", {31'd0, ign0}, 32'd1);
        chk("jal_pcu_pulse", {31'd0, pcu0}, 32'd0);
        @(posedge clk); #1;
        chk("jal_ign3", {31'd0, ign0}, 32'd0);

        // Call then matching return
        do_reset();
        jump(2'b01, 32'h200, 32'h40, 32'h0, 5'd0, 5'd1);
        settle();
        jump(2'b10, 32'h240, 32'h0, 32'h204, 5'd1, 5'd0);
        chk("ret_pcv", pcv0, 32'h204);
        chk("ret_rdw", {31'd0, rdw0}, 32'd0);
        chk("ret_cnt", {28'd0, cnt0}, 32'd0);
        chk("ret_mp", {31'd0, mp0}, 32'd0);
        settle();

        // Call then wrong return
        do_reset();
        jump(2'b01, 32'h200, 32'h40, 32'h0, 5'd0, 5'd1);
        settle();
        jump(2'b10, 32'h240, 32'h0, 32'h300, 5'd1, 5'd0);
        chk("bad_pcv", pcv0, 32'h300);
        chk("bad_mp", {31'd0, mp0}, 32'd1);
        chk("bad_cnt", {28'd0, cnt0}, 32'd0);
        @(posedge clk); #1;
        chk("bad_mp_pulse", {31'd0, mp0}, 32'd0);
        @(posedge clk); #1;

        // Overflow: 9 pushes of 0x10..0x90 into 8 entries
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            jump(2'b01, 32'(k * 16 - 4), 32'h1000, 32'h0, 5'd0, 5'd1);
            settle();
        end
        chk("ovf_cnt", {28'd0, cnt0}, 32'd8);
        chk("ovf_top", top0, 32'h90);
        // Pops must return 0x90 down to 0x20
        for (int k = 9; k >= 2; k--) begin
            jump(2'b10, 32'h4000, 32'h0, 32'(k * 16), 5'd5, 5'd0);
            chk($sformatf("pop%0d_mp", k), {31'd0, mp0}, 32'd0);
            chk($sformatf("pop%0d_cnt", k), {28'd0, cnt0}, 32'(k - 2));
            chk($sformatf("pop%0d_top", k), top0, (k > 2) ? 32'((k - 1) * 16) : 32'd0);
            settle();
        end
        jump(2'b10, 32'h4000, 32'h0, 32'h20, 5'd1, 5'd0);
        chk("unf_valid", {31'd0, rv0}, 32'd0);
        chk("unf_cnt", {28'd0, cnt0}, 32'd0);
        chk("unf_mp", {31'd0, mp0}, 32'd0);
        chk("unf_pcu", {31'd0, pcu0}, 32'd1);
        settle();

        // Misaligned JALR target 0x1002
        do_reset();
        jump(2'b01, 32'h0, 32'h10, 32'h0, 5'd0, 5'd1);
        settle();
        jump(2'b10, 32'h10, 32'h0, 32'h1002, 5'd2, 5'd1);
        chk("mis_exc", {31'd0, mis0}, 32'd1);
        chk("mis_pcu", {31'd0, pcu0}, 32'd0);
        chk("mis_rdw", {31'd0, rdw0}, 32'd0);
        chk("mis_cnt", {28'd0, cnt0}, 32'd1);
        chk("mis_top", top0, 32'h4);
        chk("mis_ign", {31'd0, ign0}, 32'd0);
        chk("al1_pcv", pcv1, 32'h1002);
        chk("al1_pcu", {31'd0, pcu1}, 32'd1);
        chk("al1_exc", {31'd0, mis1}, 32'd0);
        @(posedge clk); #1;
        chk("mis_pulse", {31'd0, mis0}, 32'd0);
        @(posedge clk); #1;

        // Jump presented during flush is ignored
        do_reset();
        jump(2'b01, 32'h100, 32'h20, 32'h0, 5'd0, 5'd1);
        @(negedge clk);
        jc = 2'b01; pc = 32'h500; imm = 32'h100; rd_idx = 5'd1; valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk($sformatf("fl%0d_pcu", i), {31'd0, pcu0}, 32'd0);
            chk($sformatf("fl%0d_pcv", i), pcv0, 32'h120);
            chk($sformatf("fl%0d_cnt", i), {28'd0, cnt0}, 32'd1);
        end
        @(negedge clk);
        valid = 1'b0;
        jc = 2'b00;

        // Reset one cycle into a flush
        jump(2'b01, 32'h100, 32'h20, 32'h0, 5'd0, 5'd1);
        chk("rmf_pre_ign", {31'd0, ign0}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rmf_ign", {31'd0, ign0}, 32'd0);
        chk("rmf_pcu", {31'd0, pcu0}, 32'd0);
        chk("rmf_pcv", pcv0, 32'd0);
        chk("rmf_rdw", {31'd0, rdw0}, 32'd0);
        chk("rmf_rdv", rdv0, 32'd0);
        chk("rmf_cnt", {28'd0, cnt0}, 32'd0);
        chk("rmf_top", top0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Flush cancelled: the next jump is accepted at once
        jump(2'b01, 32'hFFFFFFFC, 32'h8, 32'h0, 5'd0, 5'd2);
        chk("wrap_pcu", {31'd0, pcu0}, 32'd1);
        chk("wrap_pcv", pcv0, 32'h4);
        chk("wrap_rdv", rdv0, 32'h0);
        chk("wrap_rdw", {31'd0, rdw0}, 32'd1);
        chk("wrap_cnt", {28'd0, cnt0}, 32'd0);
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    // Watchdog so a stalled run still ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jump_ras_unit.md
Name: jump_ras_unit

Overview:
- Parametrised next-generation jump unit for the RISC-V core: resolves JAL/JALR, writes the link value to rd, redirects the PC, and squashes younger instructions for a configurable number of cycles.
- Adds a circular return-address stack (RAS) that follows the RISC-V link-register hints, plus misalignment detection and a return-misprediction flag.
- Sits in the execute stage beside the ALU; its outputs are registered.

Parameters:
- XLEN, 32: datapath width in bits.
- RAS_DEPTH, 8: number of RAS entries; power of 2, at least 2.
- FLUSH_CYCLES, 2: cycles ignore_curr_inst stays high after a redirect; at least 1.
- ALIGN_BITS, 2: low target bits that must be zero; 2 without the C extension, 1 with it.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_valid  in  1  instruction in execute is valid.
- pc  in  XLEN  PC of the current instruction.
- imm  in  XLEN  sign-extended immediate.
- rs1_val  in  XLEN  rs1 operand.
- rs1_idx  in  5  rs1 register index.
- rd_idx  in  5  rd register index.
- jump_control  in  2  00 none, 01 JAL, 10 JALR, 11 reserved (treated as none).
- rd_write_control  out  1  rd write enable.
- rd_write_val  out  XLEN  link value, pc+4.
- pc_update_control  out  1  redirect PC.
- pc_update_val  out  XLEN  jump target.
- ignore_curr_inst  out  1  squash the instruction currently in execute.
- misaligned_exc  out  1  one-cycle target-misaligned exception.
- ras_top  out  XLEN  top RAS entry; 0 when empty.
- ras_valid  out  1  RAS is non-empty.
- ras_count  out  $clog2(RAS_DEPTH)+1  RAS occupancy.
- ras_mispredict  out  1  popped entry did not match the target.

Behaviour:
- Reset (async, i_rst=0):
  - All outputs are 0.
  - RAS pointer and count are 0.
  - Flush counter is 0.
  - Reset in the middle of a flush cancels it immediately.
- Accept: an instruction is accepted when i_valid=1, jump_control is 01 or 10, and the flush counter is 0. While the counter is non-zero, inputs are ignored.
- Latency: every registered output reflects the accepted instruction on the next rising edge. Pulse outputs are high for exactly 1 cycle.
- Target computation, modulo 2^XLEN, wrapping with no overflow flag:
  - JAL: pc+imm.
  - JALR: (rs1_val+imm) with bit 0 cleared.
  - Link value: pc+4, modulo 2^XLEN.
- Misaligned target (target[ALIGN_BITS-1:0] != 0):
  - misaligned_exc=1.
  - No rd write, no PC update, no flush, no RAS change.
- Normal jump:
  - pc_update_control=1, pc_update_val=target.
  - rd_write_control=1 only if rd_idx != 0.
  - The flush counter loads FLUSH_CYCLES.
- Flush counter:
  - ignore_curr_inst=1 whenever the counter is non-zero.
  - The counter decrements by 1 each cycle.
  - A redirect therefore squashes FLUSH_CYCLES consecutive cycles, starting the cycle after the outputs register.
- RAS actions, applied only on an accepted, aligned jump. A link register is x1 or x5.
  - JAL with link rd: push pc+4.
  - JALR, rd link, rs1 not link: push.
  - JALR, rd not link, rs1 link: pop.
  - JALR, rd link, rs1 link, rd==rs1: push.
  - JALR, rd link, rs1 link, rd!=rs1: pop, then push. Net count is unchanged and the top is replaced.
  - Any other case: no action.
- RAS push when full: overwrite the oldest entry (circular buffer). Count saturates at RAS_DEPTH.
- RAS pop when empty: no-op, count stays 0, ras_mispredict=0.
- ras_mispredict: asserted on a non-empty pop when the popped entry != computed target. It is registered with the other outputs.
- ras_top, ras_valid and ras_count update in the same edge as the other outputs.

Test Plan:
- Reset and JAL: reset, then JAL with pc=0x100, imm=0x20, rd=1 → next cycle:
  - rd_write_val=0x104, pc_update_val=0x120, pc_update_control=1.
  - ras_top=0x104, ras_count=1.
  - ignore_curr_inst high for exactly 2 cycles.
- Call then return: JAL pc=0x200, rd=1, then JALR rs1=1, rs1_val=0x204, imm=0, rd=0 → pc_update_val=0x204, rd_write_control=0, ras_count=0, ras_mispredict=0. Same sequence with rs1_val=0x300 → ras_mispredict=1.
- Overflow and underflow: 9 pushes of 0x10, 0x20, …, 0x90 → ras_count=8, ras_top=0x90; 8 pops return 0x90…0x20 in order; a 9th pop → no-op, ras_valid=0.
- Misaligned target: JALR rs1_val=0x1002, imm=0 with ALIGN_BITS=2 → misaligned_exc=1, pc_update_control=0, rd_write_control=0, RAS unchanged. Same input with ALIGN_BITS=1 → pc_update_val=0x1002, no exception.
- Jump during flush: a JAL is accepted, then another JAL is presented during the 2 flush cycles → second jump ignored, no second redirect, RAS unchanged.
- Reset mid-flush and wrap: assert i_rst=0 one cycle into a flush → all outputs 0 immediately. Separately, JAL pc=0xFFFFFFFC, imm=8 → pc_update_val=0x4, rd_write_val=0x0.
